melody_sequencer: RTL

//  Upstream stage of the tone generator (montek_sound_Nexys4): walks a fixed song table,

---
 rtl/melody_sequencer.sv | 115 +++++++++++
 1 files changed

// File: rtl/melody_sequencer.sv
// Song-table walker feeding note periods to the tone generator.
// Define MELODY_LOOP_EN to replay the song until stop instead of idling.
module melody_sequencer #(
  parameter int unsigned BEAT_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 1_000_000,
  parameter int unsigned SONG_LEN    = 16,
  localparam int unsigned IW = $clog2(SONG_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  output logic [31:0]   period,
  output logic          playing,
  output logic [IW-1:0] note_idx,
  output logic          done
);

`ifdef MELODY_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t      state;
  logic [31:0] cnt;

  function automatic logic [7:0] song(input logic [IW-1:0] i);
    int n;
    n = int'(i);
    if (n < 8)       return {4'(n), 4'd1};
    else if (n == 8) return {4'hf, 4'd2};
    else             return 8'h00;
  endfunction

  function automatic logic [31:0] note_period(input logic [3:0] n);
    case (n)
      4'd0:    return 32'd382219;
      4'd1:    return 32'd340530;
      4'd2:    return 32'd303370;
      4'd3:    return 32'd286344;
      4'd4:    return 32'd255102;
      4'd5:    return 32'd227273;
      4'd6:    return 32'd202478;
      4'd7:    return 32'd191113;
      default: return 32'd0;
    endcase
  endfunction

  logic [IW-1:0] nxt_idx, ld_idx;
  logic [7:0]    nxt_ent, ld_ent;
  logic [31:0]   ld_full, ld_cnt, ld_period;
  logic          song_end, adv, load, fin;

  always_comb begin
    nxt_idx  = (state == IDLE) ? '0 : note_idx + 1'b1;
    nxt_ent  = song(nxt_idx);
    song_end = (state != IDLE && note_idx == IW'(SONG_LEN - 1))
             || nxt_ent[3:0] == 4'd0;
    ld_idx   = (LOOP && song_end && state != IDLE) ? '0 : nxt_idx;
    ld_ent   = song(ld_idx);
    ld_full  = 32'(ld_ent[3:0]) * 32'(BEAT_CYCLES);
    ld_period = note_period(ld_ent[7:4]);
    // Rests take the whole slot; sounded notes leave room for the gap.
    ld_cnt   = (ld_period == 32'd0) ? ld_full - 32'd1
             : ld_full - 32'(GAP_CYCLES) - 32'd1;
    adv  = (state == PLAY && cnt == 32'd0 && period == 32'd0)
        || (state == GAP && cnt == 32'd0);
    load = (state == IDLE && start && !song_end)
        || (adv && (!song_end || LOOP));
    fin  = (state == IDLE && start && song_end) || (adv && song_end);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      period   <= '0;
      playing  <= 1'b0;
      note_idx <= '0;
      done     <= 1'b0;
    end else if (stop) begin
      state    <= IDLE;
      cnt      <= '0;
      period   <= '0;
      playing  <= 1'b0;
      note_idx <= '0;
      done     <= 1'b0;
    end else begin
      done <= fin;
      if (load) begin
        state    <= PLAY;
        cnt      <= ld_cnt;
        period   <= ld_period;
        playing  <= 1'b1;
        note_idx <= ld_idx;
      end else if (fin) begin
        state    <= IDLE;
        cnt      <= '0;
        period   <= '0;
        playing  <= 1'b0;
        note_idx <= '0;
      end else if (state == PLAY && cnt == 32'd0) begin
        state  <= GAP;
        cnt    <= 32'(GAP_CYCLES) - 32'd1;
        period <= '0;
      end else if (cnt != 32'd0) begin
        cnt <= cnt - 32'd1;
      end
    end
  end

endmodule
